// File: rtl/gomoku_pkg.sv
// Shared constants and types for the gomoku board/display path.
// Geometry, colours, FSM states and turn encoding live here.
package gomoku_pkg;

   localparam int BOARD_N  = 7;
   localparam int SPRITE   = 15;
   localparam int PITCH    = 16;
   localparam int ORIGIN_X = 24;
   localparam int ORIGIN_Y = 4;

   localparam logic [2:0] BLACK_COL = 3'b000;
   localparam logic [2:0] WHITE_COL = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      COMMIT,
      DRAW,
      DONE
   } state_t;

   typedef enum logic {
      BLACK = 1'b0,
      WHITE = 1'b1
   } turn_t;

   // Pixel origin of a cell along one axis
   function automatic logic [7:0] cell_org(
      input logic [2:0] c,
      input int         org
   );
      return 8'(org + PITCH * int'(c));
   endfunction

endpackage

// File: rtl/stone_sprite_rom.sv
// Disc sprite for a placed stone: one 15-bit row per lookup.
// Bit (14-sx) of the row is pixel column sx.
module stone_sprite_rom
   import gomoku_pkg::*;
(
   input  logic [3:0]  row,
   output logic [14:0] mask
);

   // Row lookup of the disc shape
   always_comb begin
      mask = '0;
      unique case (row)
         4'd0:    mask = 15'h07C0;
         4'd1:    mask = 15'h1FF0;
         4'd2:    mask = 15'h3FF8;
         4'd3:    mask = 15'h7FFC;
         4'd4:    mask = 15'h7FFC;
         4'd5:    mask = 15'h7FFF;
         4'd6:    mask = 15'h7FFF;
         4'd7:    mask = 15'h7FFF;
         4'd8:    mask = 15'h7FFF;
         4'd9:    mask = 15'h7FFF;
         4'd10:   mask = 15'h7FFC;
         4'd11:   mask = 15'h7FFC;
         4'd12:   mask = 15'h3FF8;
         4'd13:   mask = 15'h1FF0;
         4'd14:   mask = 15'h07C0;
         default: mask = '0;
      endcase
   end

endmodule

// File: rtl/stone_plotter.sv
// Validates a move, strobes the board load, draws the stone,
// then passes the turn to the other side.
module stone_plotter
   import gomoku_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       req,
   input  logic [2:0] cur_x,
   input  logic [2:0] cur_y,
   input  logic       cell_occupied,
   input  logic [1:0] game_state,
   output logic [2:0] move_x,
   output logic [2:0] move_y,
   output logic       move_color,
   output logic       commit,
   output logic       busy,
   output logic       reject,
   output logic       done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       plot
);

   localparam logic [3:0] LAST = 4'(SPRITE - 1);

   state_t      state, state_n;
   logic [3:0]  sx, sy, sx_n, sy_n;
   logic [3:0]  col_idx;
   logic [14:0] mask;
   logic        bad, last, rej_q;

   stone_sprite_rom u_rom (
      .row  (sy_n),
      .mask (mask)
   );

   assign bad = cell_occupied
             || (game_state != 2'd0)
             || (move_x >= 3'(BOARD_N))
             || (move_y >= 3'(BOARD_N));

   assign last    = (sx == LAST) && (sy == LAST);
   assign col_idx = LAST - sx_n;

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) state <= IDLE;
      else         state <= state_n;
   end

   // Next state and sprite scan order (row outer, column inner)
   always_comb begin
      state_n = state;
      sx_n    = sx;
      sy_n    = sy;
      unique case (state)
         IDLE:   if (req) state_n = CHECK;
         CHECK:  state_n = bad ? DONE : COMMIT;
         COMMIT: begin
            state_n = DRAW;
            sx_n    = '0;
            sy_n    = '0;
         end
         DRAW: begin
            if (last) begin
               state_n = DONE;
            end else if (sx == LAST) begin
               sx_n = '0;
               sy_n = sy + 4'd1;
            end else begin
               sx_n = sx + 4'd1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Registered outputs, move latch and turn hand-over
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         move_x     <= 3'd3;
         move_y     <= 3'd3;
         move_color <= BLACK;
         commit     <= 1'b0;
         reject     <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         plot       <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         sx         <= '0;
         sy         <= '0;
         rej_q      <= 1'b0;
      end else begin
         commit <= (state == CHECK) && !bad;
         reject <= (state == CHECK) && bad;
         done   <= (state == DRAW) && last;
         busy   <= (state_n != IDLE);
         plot   <= (state_n == DRAW) && mask[col_idx];
         sx     <= sx_n;
         sy     <= sy_n;
         if (state_n == DRAW) begin
            vga_x <= cell_org(move_x, ORIGIN_X)
                   + {4'b0, sx_n};
            vga_y <= 7'(cell_org(move_y, ORIGIN_Y)
                   + {4'b0, sy_n});
            vga_colour <= move_color ? WHITE_COL
                                     : BLACK_COL;
         end
         if ((state == IDLE) && req) begin
            move_x <= cur_x;
            move_y <= cur_y;
         end
         if (state == CHECK) rej_q <= bad;
         if ((state == DONE) && !rej_q)
            move_color <= ~move_color;
      end
   end

endmodule

// File: tb/tb_stone_plotter.sv
// Randomised bench for stone_plotter against a move-level
// model of the board, the turn and the disc sprite.
module tb_stone_plotter;

   logic       CLOCK_50 = 1'b0;
   logic       resetn;
   logic       req;
   logic [2:0] cur_x, cur_y;
   logic       cell_occupied;
   logic [1:0] game_state;
   logic [2:0] move_x, move_y;
   logic       move_color, commit, busy;
   logic       reject, done, plot;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;

   int checks   = 0;
   int failures = 0;

   bit board [0:7][0:7];
   bit color_m;
   int mask_tab [15] = '{
      'h07C0, 'h1FF0, 'h3FF8, 'h7FFC, 'h7FFC,
      'h7FFF, 'h7FFF, 'h7FFF, 'h7FFF, 'h7FFF,
      'h7FFC, 'h7FFC, 'h3FF8, 'h1FF0, 'h07C0
   };
   int disc_pop;

   always #10 CLOCK_50 = ~CLOCK_50;

   assign cell_occupied =
      (move_x < 3'd7 && move_y < 3'd7)
         ? board[move_x][move_y] : 1'b0;

   stone_plotter dut (
      .CLOCK_50      (CLOCK_50),
      .resetn        (resetn),
      .req           (req),
      .cur_x         (cur_x),
      .cur_y         (cur_y),
      .cell_occupied (cell_occupied),
      .game_state    (game_state),
      .move_x        (move_x),
      .move_y        (move_y),
      .move_color    (move_color),
      .commit        (commit),
      .busy          (busy),
      .reject        (reject),
      .done          (done),
      .vga_x         (vga_x),
      .vga_y         (vga_y),
      .vga_colour    (vga_colour),
      .plot          (plot)
   );

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d",
                  tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},   busy, 0);
      chk({tag, "_plot"},   plot, 0);
      chk({tag, "_commit"}, commit, 0);
      chk({tag, "_reject"}, reject, 0);
      chk({tag, "_done"},   done, 0);
      chk({tag, "_mx"},     move_x, 3);
      chk({tag, "_my"},     move_y, 3);
      chk({tag, "_color"},  move_color, 0);
      chk({tag, "_vx"},     vga_x, 0);
      chk({tag, "_vy"},     vga_y, 0);
      chk({tag, "_vc"},     vga_colour, 0);
   endtask

   // One request; abort_at>0 pulls reset in that cycle
   task automatic do_move(
      input int  x,
      input int  y,
      input int  gs,
      input bit  extra,
      input int  abort_at
   );
      bit acc, ecol, eb, ep;
      int ncom, nrej, ndone, nplot;
      int comc, rejc, donec;
      int pixbad, busybad, cbad, maxx, maxy;
      int idx, sx, sy;
      acc = (x < 7) && (y < 7) && (gs == 0)
         && !board[x][y];
      if (!acc) extra = 0;
      ecol = color_m;
      ncom = 0; nrej = 0; ndone = 0; nplot = 0;
      comc = -1; rejc = -1; donec = -1;
      pixbad = 0; busybad = 0; cbad = 0;
      maxx = 0; maxy = 0;
      @(negedge CLOCK_50);
      cur_x = 3'(x);
      cur_y = 3'(y);
      game_state = 2'(gs);
      req = 1'b1;
      for (int c = 1; c <= 232; c++) begin
         @(negedge CLOCK_50);
         req = extra && (c == 1 || c == 50 || c == 200);
         if (commit) begin
            ncom++;
            comc = c;
            if (move_color !== ecol) cbad++;
            if (move_x !== 3'(x)) cbad++;
            if (move_y !== 3'(y)) cbad++;
         end
         if (reject) begin nrej++; rejc = c; end
         if (done) begin ndone++; donec = c; end
         if (plot) nplot++;
         eb = acc ? (c <= 228) : (c <= 2);
         if (abort_at != 0 && c > abort_at) eb = 0;
         if (busy !== eb) busybad++;
         if (acc && c >= 3 && c <= 227) begin
            idx = c - 3;
            sy  = idx / 15;
            sx  = idx % 15;
            ep  = ((mask_tab[sy] >> (14 - sx)) & 1) != 0;
            if (plot !== ep) pixbad++;
            if (vga_x !== 8'(24 + 16 * x + sx)) pixbad++;
            if (vga_y !== 7'(4 + 16 * y + sy)) pixbad++;
            if (vga_colour !== (ecol ? 3'b111 : 3'b000))
               pixbad++;
            if (int'(vga_x) > maxx) maxx = int'(vga_x);
            if (int'(vga_y) > maxy) maxy = int'(vga_y);
         end else if (plot) begin
            pixbad++;
         end
         if (abort_at != 0 && c == abort_at) begin
            resetn = 1'b0;
            @(negedge CLOCK_50);
            chk("abort_commit", ncom, 1);
            chk("abort_pix", pixbad, 0);
            chk_reset_vals("abort");
            resetn = 1'b1;
            color_m = 0;
            board[x][y] = 1;
            return;
         end
         if (c == 229)
            chk("turn_after", move_color,
                acc ? !ecol : ecol);
      end
      req = 1'b0;
      chk("commit_cnt", ncom, acc ? 1 : 0);
      chk("reject_cnt", nrej, acc ? 0 : 1);
      chk("done_cnt", ndone, acc ? 1 : 0);
      chk("plot_cnt", nplot, acc ? disc_pop : 0);
      chk("pixels", pixbad, 0);
      chk("busy", busybad, 0);
      chk("commit_hold", cbad, 0);
      if (acc) begin
         chk("commit_cyc", comc, 2);
         chk("done_cyc", donec, 228);
         chk("max_vx", maxx, 24 + 16 * x + 14);
         chk("max_vy", maxy, 4 + 16 * y + 14);
         color_m = !ecol;
         board[x][y] = 1;
      end else begin
         chk("reject_cyc", rejc, 2);
      end
   endtask

   initial begin
      int rx, ry, rg;
      disc_pop = 0;
      for (int r = 0; r < 15; r++)
         disc_pop += $countones(mask_tab[r]);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            board[i][j] = 0;
      color_m    = 0;
      resetn     = 1'b0;
      req        = 1'b0;
      cur_x      = '0;
      cur_y      = '0;
      game_state = '0;
      repeat (3) @(negedge CLOCK_50);
      chk_reset_vals("reset");
      resetn = 1'b1;
      @(negedge CLOCK_50);

      do_move(3, 3, 0, 0, 0);
      do_move(3, 3, 0, 0, 0);
      do_move(0, 0, 1, 0, 0);
      do_move(1, 2, 0, 1, 0);
      do_move(6, 6, 0, 0, 0);
      do_move(5, 6, 0, 0, 0);
      do_move(7, 2, 0, 0, 0);
      do_move(2, 2, 0, 0, 100);
      do_move(4, 4, 0, 0, 0);

      for (int n = 0; n < 14; n++) begin
         rx = int'($urandom_range(0, 7));
         ry = int'($urandom_range(0, 7));
         rg = ($urandom_range(0, 4) == 0)
            ? int'($urandom_range(1, 2)) : 0;
         do_move(rx, ry, rg,
                 bit'($urandom_range(0, 1)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
